// File: rtl/program_loader.sv
// program_loader: receives a framed program image over a byte stream and
// writes it into instruction memory, holding the core in reset until a
// frame with a good checksum has been fully loaded.
module program_loader #(
  parameter int          MAX_WORDS    = 4096,
  parameter logic [15:0] BASE_ADDRESS = 16'h0000,
  parameter int          TIMEOUT      = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam logic [7:0]  HEADER = 8'hA5;
  localparam logic [16:0] MAXW   = 17'(MAX_WORDS);
  localparam int          TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t        state;
  logic [7:0]    chk;       // running XOR of length and data bytes
  logic [7:0]    len_hi;
  logic [15:0]   len;
  logic [7:0]    hi;
  logic [15:0]   idx;       // index of the next word to be written
  logic [TW-1:0] tcnt;      // idle cycles since the last byte in a frame

  logic hdr;
  assign hdr = rx_valid && (rx_data == HEADER);

  // Frame FSM with registered memory-write and status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      chk         <= '0;
      len_hi      <= '0;
      len         <= '0;
      hi          <= '0;
      idx         <= '0;
      tcnt        <= '0;
      mem_write   <= 1'b0;
      mem_address <= BASE_ADDRESS;
      mem_data    <= '0;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      case (state)
        // Only a header byte starts a frame; done/error/cpu_reset are
        // brought back to the loading condition on every (re)start.
        S_IDLE, S_DONE, S_ERROR: begin
          if (hdr) begin
            state     <= S_LEN_HI;
            chk       <= '0;
            idx       <= '0;
            tcnt      <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
          end
        end
        // Inside a frame every byte (0xA5 included) is payload.
        default: begin
          if (rx_valid) begin
            tcnt <= '0;
            case (state)
              S_LEN_HI: begin
                len_hi <= rx_data;
                chk    <= chk ^ rx_data;
                state  <= S_LEN_LO;
              end
              S_LEN_LO: begin
                len <= {len_hi, rx_data};
                chk <= chk ^ rx_data;
                if ({1'b0, len_hi, rx_data} > MAXW) begin
                  state <= S_ERROR;
                  error <= 1'b1;
                end else if ({len_hi, rx_data} == 16'd0) begin
                  state <= S_CHECK;
                end else begin
                  state <= S_DATA_HI;
                end
              end
              S_DATA_HI: begin
                hi    <= rx_data;
                chk   <= chk ^ rx_data;
                state <= S_DATA_LO;
              end
              S_DATA_LO: begin
                chk         <= chk ^ rx_data;
                mem_write   <= 1'b1;
                mem_address <= BASE_ADDRESS + idx;
                mem_data    <= {hi, rx_data};
                idx         <= idx + 16'd1;
                state       <= (idx == len - 16'd1) ? S_CHECK : S_DATA_HI;
              end
              S_CHECK: begin
                if (rx_data == chk) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
                end else begin
                  state <= S_ERROR;
                  error <= 1'b1;
                end
              end
              default: state <= S_IDLE;
            endcase
          end else if (tcnt == TLAST) begin
            // Sender went quiet mid-frame: abandon the frame.
            state <= S_ERROR;
            error <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frames are built from word lists, expected
// memory writes go into a scoreboard queue and a monitor checks every
// write pulse the DUT produces against it.
module tb_program_loader;

  localparam int          MAXW = 4096;
  localparam logic [15:0] BASE = 16'hFFFC;
  localparam int          TMO  = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        mem_write;
  logic [15:0] mem_address, mem_data;
  logic        cpu_reset, done, error;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];      // {address, data} of each expected write
  logic [15:0] frame_words[$];

  program_loader #(.MAX_WORDS(MAXW), .BASE_ADDRESS(BASE), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clock) begin
    if (reset && mem_write) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: got %0h:%0h, expected none", mem_address, mem_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({mem_address, mem_data} !== e) begin
          mismatched++;
          $display("FAIL write: got %0h:%0h, expected %0h:%0h",
                   mem_address, mem_data, e[31:16], e[15:0]);
        end
      end
    end
  end

  // Called at a falling edge; presents one byte for one cycle, then idles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], 0);
  endtask

  // Sends a complete frame built from frame_words and checks the outcome.
  task automatic run_frame(input bit bad, input int gap_max, input string name);
    logic [7:0]  q[$];
    logic [7:0]  c;
    logic [15:0] n;
    n = 16'(frame_words.size());
    q = {8'hA5, n[15:8], n[7:0]};
    foreach (frame_words[i]) begin
      q.push_back(frame_words[i][15:8]);
      q.push_back(frame_words[i][7:0]);
    end
    c = 8'h00;
    for (int i = 1; i < q.size(); i++) c = c ^ q[i];
    if (bad) c = c ^ 8'($urandom_range(1, 255));
    q.push_back(c);
    foreach (frame_words[i]) exp_q.push_back({16'(BASE + 16'(i)), frame_words[i]});
    for (int i = 0; i < q.size(); i++)
      send_byte(q[i], (i == q.size() - 1) ? 0 : $urandom_range(0, gap_max));
    check({name, "_done"},      32'(done),      32'(!bad));
    check({name, "_error"},     32'(error),     32'(bad));
    check({name, "_cpu_reset"}, 32'(cpu_reset), 32'(bad));
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clock);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'(BASE));
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Good frame, back-to-back bytes
    frame_words = {16'h1234, 16'hABCD};
    run_frame(1'b0, 0, "good");

    // Header after DONE restarts on the next cycle
    send_byte(8'hA5, 0);
    check("reload_done", 32'(done), 32'd0);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    // Finish that frame with a wrong checksum (0x43 instead of 0x42)
    exp_q.push_back({16'(BASE), 16'h1234});
    exp_q.push_back({16'(BASE + 16'd1), 16'hABCD});
    send_list({8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43});
    check("badchk_error", 32'(error), 32'd1);
    check("badchk_done", 32'(done), 32'd0);
    check("badchk_cpu_reset", 32'(cpu_reset), 32'd1);

    // Empty program
    frame_words = {};
    run_frame(1'b0, 1, "empty");

    // Oversize length 0x1001
    send_list({8'hA5, 8'h10, 8'h01});
    check("oversize_error", 32'(error), 32'd1);
    check("oversize_done", 32'(done), 32'd0);

    // Timeout mid-word, then recovery
    send_list({8'hA5, 8'h00, 8'h01, 8'h12});
    repeat (TMO / 2) @(negedge clock);
    check("timeout_early_error", 32'(error), 32'd0);
    repeat (TMO) @(negedge clock);
    check("timeout_error", 32'(error), 32'd1);
    frame_words = {16'h55AA};
    run_frame(1'b0, 0, "recover");

    // Reset mid-frame: no write may follow
    send_list({8'hA5, 8'h00, 8'h02, 8'h12});
    reset = 1'b0;
    #1;
    check("midrst_mem_write", 32'(mem_write), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    // IDLE ignores non-header bytes
    send_list({8'h00, 8'h01, 8'h34, 8'h56, 8'h34});
    check("idle_ignore_done", 32'(done), 32'd0);
    check("idle_ignore_error", 32'(error), 32'd0);

    // Random frames with gaps, junk between frames and 0xA5 payload bytes
    for (int f = 0; f < 30; f++) begin
      int   n;
      logic pd, pe;
      pd = done;
      pe = error;
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] j;
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h5A;
        send_byte(j, $urandom_range(0, 2));
      end
      check("junk_done", 32'(done), 32'(pd));
      check("junk_error", 32'(error), 32'(pe));
      n = $urandom_range(0, 8);
      frame_words = {};
      repeat (n) frame_words.push_back(($urandom_range(0, 3) == 0) ? 16'hA5A5
                                       : 16'($urandom_range(0, 65535)));
      run_frame($urandom_range(0, 3) == 0, 3, "rand");
    end

    repeat (3) @(negedge clock);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
